riscv_hazard_fwd: RTL and testbench

RISCV_HAZARD_FWD -- requirements
Module: riscv_hazard_fwd

---
 rtl/riscv_hazard_pkg.sv | 20 ++
 rtl/riscv_hazard_match.sv | 42 ++++
 rtl/riscv_hazard_fwd.sv | 191 +++++++++++++++++++
 tb/tb_riscv_hazard_fwd.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the RISC-V hazard / forwarding unit.
package riscv_hazard_pkg;

  localparam int unsigned REG_AW = 5;

  // Forward select for an E-stage operand, named after where the producer
  // sits once the consumer reaches E.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_B  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/riscv_hazard_match.sv
// Compares one D-stage source operand against the E/M/B destinations and
// produces per-stage match flags plus the prioritised forward select.
module riscv_hazard_match
  import riscv_hazard_pkg::*;
(
  input  logic              src_en_i,
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [REG_AW-1:0] dst_addr_e_i,
  input  logic [REG_AW-1:0] dst_addr_m_i,
  input  logic [REG_AW-1:0] dst_addr_b_i,
  input  logic              wen_e_i,
  input  logic              wen_m_i,
  input  logic              wen_b_i,
  output logic              match_e_o,
  output logic              match_m_o,
  output logic              match_b_o,
  output fwd_sel_e          sel_o
);

  logic live;

  // Per-stage RAW compare; x0 never creates a dependency.
  always_comb begin
    live      = src_en_i & (src_addr_i != '0);
    match_e_o = live & wen_e_i & (src_addr_i == dst_addr_e_i);
    match_m_o = live & wen_m_i & (src_addr_i == dst_addr_m_i);
    match_b_o = live & wen_b_i & (src_addr_i == dst_addr_b_i);
  end

  // Youngest producer wins: E, then M, then B.
  always_comb begin
    sel_o = FWD_RF;
    if (match_e_o) begin
      sel_o = FWD_M;
    end else if (match_m_o) begin
      sel_o = FWD_B;
    end else if (match_b_o) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/riscv_hazard_fwd.sv
// Pipeline hazard, stall/flush and operand forwarding control.
module riscv_hazard_fwd
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             i_src_en,
  input  logic [NUM_SRC-1:0][REG_AW-1:0] i_src_addr,
  input  logic [REG_AW-1:0]              i_dst_addrE,
  input  logic [REG_AW-1:0]              i_dst_addrM,
  input  logic [REG_AW-1:0]              i_dst_addrB,
  input  logic                           i_dst_wenE,
  input  logic                           i_dst_wenM,
  input  logic                           i_dst_wenB,
  input  logic                           i_loadE,
  input  logic                           i_jalD,
  input  logic                           i_branchE,
  input  logic                           i_bus_stallM,
  input  logic                           i_mdu_startE,
  input  logic                           i_mdu_doneE,
  input  logic                           i_cnt_clr,
  output logic                           o_enF,
  output logic                           o_enFD,
  output logic                           o_enDE,
  output logic                           o_enEM,
  output logic                           o_enMB,
  output logic                           o_flushFD,
  output logic                           o_flushDE,
  output logic                           o_flushEM,
  output logic                           o_flushMB,
  output logic [NUM_SRC-1:0][1:0]        o_fwd_selE,
  output logic                           o_mdu_busy,
  output logic [CNT_W-1:0]               o_stall_cnt
);

  logic [NUM_SRC-1:0]      match_e;
  logic [NUM_SRC-1:0]      match_m;
  logic [NUM_SRC-1:0]      match_b;
  fwd_sel_e                sel_w [NUM_SRC];

  logic                    load_use;
  logic                    raw;
  logic                    hazard;
  logic                    mdu_stall;

  mdu_state_e              state_q, state_d;
  logic [NUM_SRC-1:0][1:0] fwd_q, fwd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    riscv_hazard_match u_match (
      .src_en_i     (i_src_en[g]),
      .src_addr_i   (i_src_addr[g]),
      .dst_addr_e_i (i_dst_addrE),
      .dst_addr_m_i (i_dst_addrM),
      .dst_addr_b_i (i_dst_addrB),
      .wen_e_i      (i_dst_wenE),
      .wen_m_i      (i_dst_wenM),
      .wen_b_i      (i_dst_wenB),
      .match_e_o    (match_e[g]),
      .match_m_o    (match_m[g]),
      .match_b_o    (match_b[g]),
      .sel_o        (sel_w[g])
    );
  end

  // Hazard classification across all sources.
  always_comb begin
    load_use = (|match_e) & i_loadE;
    raw      = |(match_e | match_m | match_b);
    hazard   = (FWD_EN != 0) ? load_use : raw;
  end

  // MDU FSM next state and stall; a start that completes at once never stalls.
  always_comb begin
    state_d   = state_q;
    mdu_stall = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        mdu_stall = i_mdu_startE & ~i_mdu_doneE;
        if (i_mdu_startE & ~i_bus_stallM & ~i_mdu_doneE) begin
          state_d = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        mdu_stall = ~i_mdu_doneE;
        if (i_mdu_doneE) begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // MDU state register; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_mdu_busy = rst_n & (state_q == MDU_BUSY);

  // Stage enables and flushes, first matching condition wins.
  always_comb begin
    o_enF     = 1'b1;
    o_enFD    = 1'b1;
    o_enDE    = 1'b1;
    o_enEM    = 1'b1;
    o_enMB    = 1'b1;
    o_flushFD = 1'b0;
    o_flushDE = 1'b0;
    o_flushEM = 1'b0;
    o_flushMB = 1'b0;
    if (!rst_n) begin
      o_flushFD = 1'b1;
      o_flushDE = 1'b1;
      o_flushEM = 1'b1;
      o_flushMB = 1'b1;
    end else if (i_bus_stallM) begin
      o_enF     = 1'b0;
      o_enFD    = 1'b0;
      o_enDE    = 1'b0;
      o_enEM    = 1'b0;
      o_flushMB = 1'b1;
    end else if (mdu_stall) begin
      o_enF     = 1'b0;
      o_enFD    = 1'b0;
      o_enDE    = 1'b0;
      o_flushEM = 1'b1;
    end else if (i_branchE) begin
      o_flushFD = 1'b1;
      o_flushDE = 1'b1;
    end else if (hazard) begin
      o_enF     = 1'b0;
      o_enFD    = 1'b0;
      o_flushDE = 1'b1;
    end else if (i_jalD) begin
      o_flushFD = 1'b1;
    end
  end

  // Forward select for the instruction entering E.
  always_comb begin
    fwd_d = '0;
    if (!o_flushDE && (FWD_EN != 0)) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        fwd_d[k] = sel_w[k];
      end
    end
  end

  // Forward select register follows the D/E pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_q <= '0;
    end else if (o_enDE) begin
      fwd_q <= fwd_d;
    end
  end

  assign o_fwd_selE = fwd_q;

  // Saturating stall counter; clear overrides counting.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (!o_enF && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_hazard_fwd.sv
// Self-checking bench: two configurations driven with the same stimulus and
// compared every cycle against a rule-level reference model.
module tb_riscv_hazard_fwd;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      src_en;
  logic [2:0][4:0] src_addr;
  logic [4:0]      dstE, dstM, dstB;
  logic            wenE, wenM, wenB, loadE, jalD, branchE, bus, start, done, clr;

  // {enF, enFD, enDE, enEM, enMB, flushFD, flushDE, flushEM, flushMB}
  logic [8:0]      a_ctl, b_ctl;
  logic [1:0][1:0] a_sel;
  logic [2:0][1:0] b_sel;
  logic            a_busy, b_busy;
  logic [3:0]      a_cnt;
  logic [31:0]     b_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy;
  int          m_sel_a [3];
  int          m_sel_b [3];
  int          m_cnt_a;
  logic [31:0] m_cnt_b;

  always #5 clk = ~clk;

  riscv_hazard_fwd #(.NUM_SRC(2), .FWD_EN(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_src_en(src_en[1:0]), .i_src_addr(src_addr[1:0]),
    .i_dst_addrE(dstE), .i_dst_addrM(dstM), .i_dst_addrB(dstB),
    .i_dst_wenE(wenE), .i_dst_wenM(wenM), .i_dst_wenB(wenB), .i_loadE(loadE),
    .i_jalD(jalD), .i_branchE(branchE), .i_bus_stallM(bus),
    .i_mdu_startE(start), .i_mdu_doneE(done), .i_cnt_clr(clr),
    .o_enF(a_ctl[8]), .o_enFD(a_ctl[7]), .o_enDE(a_ctl[6]), .o_enEM(a_ctl[5]), .o_enMB(a_ctl[4]),
    .o_flushFD(a_ctl[3]), .o_flushDE(a_ctl[2]), .o_flushEM(a_ctl[1]), .o_flushMB(a_ctl[0]),
    .o_fwd_selE(a_sel), .o_mdu_busy(a_busy), .o_stall_cnt(a_cnt)
  );

  riscv_hazard_fwd #(.NUM_SRC(3), .FWD_EN(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_src_en(src_en), .i_src_addr(src_addr),
    .i_dst_addrE(dstE), .i_dst_addrM(dstM), .i_dst_addrB(dstB),
    .i_dst_wenE(wenE), .i_dst_wenM(wenM), .i_dst_wenB(wenB), .i_loadE(loadE),
    .i_jalD(jalD), .i_branchE(branchE), .i_bus_stallM(bus),
    .i_mdu_startE(start), .i_mdu_doneE(done), .i_cnt_clr(clr),
    .o_enF(b_ctl[8]), .o_enFD(b_ctl[7]), .o_enDE(b_ctl[6]), .o_enEM(b_ctl[5]), .o_enMB(b_ctl[4]),
    .o_flushFD(b_ctl[3]), .o_flushDE(b_ctl[2]), .o_flushEM(b_ctl[1]), .o_flushMB(b_ctl[0]),
    .o_fwd_selE(b_sel), .o_mdu_busy(b_busy), .o_stall_cnt(b_cnt)
  );

  // Nearest stage (1=E, 2=M, 3=B) holding the producer of source k, 0 if none.
  function automatic int stage_hit(int k);
    logic [4:0] d [3];
    bit         w [3];
    d = '{dstE, dstM, dstB};
    w = '{wenE, wenM, wenB};
    for (int s = 0; s < 3; s++)
      if (src_en[k] && src_addr[k] != 5'd0 && w[s] && src_addr[k] == d[s]) return s + 1;
    return 0;
  endfunction

  // Winning condition: 0 none, 1 bus, 2 mdu, 3 branch, 4 hazard, 5 jal, 6 reset.
  function automatic int cause(int fwd_en, int nsrc);
    bit hz = 0;
    int h;
    if (!rst_n) return 6;
    if (bus) return 1;
    if (m_busy ? !done : (start && !done)) return 2;
    if (branchE) return 3;
    for (int k = 0; k < nsrc; k++) begin
      h = stage_hit(k);
      if (fwd_en != 0 ? (h == 1 && loadE) : (h != 0)) hz = 1;
    end
    if (hz) return 4;
    if (jalD) return 5;
    return 0;
  endfunction

  function automatic logic [8:0] tbl(int c);
    case (c)
      1:       return 9'b00001_0001;
      2:       return 9'b00011_0010;
      3:       return 9'b11111_1100;
      4:       return 9'b00111_0100;
      5:       return 9'b11111_1000;
      6:       return 9'b11111_1111;
      default: return 9'b11111_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Check the current cycle, then advance model and DUT by one clock.
  task automatic cycle();
    int ca, cb;
    logic [8:0] ea, eb;
    #1;
    ca = cause(1, 2);
    cb = cause(0, 3);
    ea = tbl(ca);
    eb = tbl(cb);
    chk("ctl_a", a_ctl, ea);
    chk("ctl_b", b_ctl, eb);
    chk("sel_a", a_sel, {2'(m_sel_a[1]), 2'(m_sel_a[0])});
    chk("sel_b", b_sel, {2'(m_sel_b[2]), 2'(m_sel_b[1]), 2'(m_sel_b[0])});
    chk("cnt_a", a_cnt, m_cnt_a);
    chk("cnt_b", b_cnt, m_cnt_b);
    chk("busy_a", a_busy, rst_n ? m_busy : 1'b0);
    chk("busy_b", b_busy, rst_n ? m_busy : 1'b0);
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_cnt_a = 0; m_cnt_b = '0;
      for (int k = 0; k < 3; k++) begin m_sel_a[k] = 0; m_sel_b[k] = 0; end
    end else begin
      if (ea[6]) for (int k = 0; k < 2; k++) m_sel_a[k] = ea[2] ? 0 : stage_hit(k);
      if (eb[6]) for (int k = 0; k < 3; k++) m_sel_b[k] = 0;
      if (clr) m_cnt_a = 0; else if (!ea[8] && m_cnt_a != 15) m_cnt_a++;
      if (clr) m_cnt_b = '0; else if (!eb[8] && m_cnt_b != '1) m_cnt_b++;
      m_busy = m_busy ? !done : (start && !bus && !done);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1; src_en = '0; src_addr = '0; dstE = '0; dstM = '0; dstB = '0;
    wenE = 0; wenM = 0; wenB = 0; loadE = 0; jalD = 0; branchE = 0;
    bus = 0; start = 0; done = 0; clr = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    m_busy = 0; m_cnt_a = 0; m_cnt_b = '0;
    for (int k = 0; k < 3; k++) begin m_sel_a[k] = 0; m_sel_b[k] = 0; end
    cycle();
    cycle();
    chk("rst_ctl", a_ctl, 9'b11111_1111);

    // ALU result in E forwarded: no stall, select M next cycle
    idle(); src_en = 3'b001; src_addr[0] = 5'd5; dstE = 5'd5; wenE = 1;
    cycle();
    chk("fwd_e_sel", a_sel[0], 2'd1);

    // Load-use on src1, then producer in M
    idle(); src_en = 3'b010; src_addr[1] = 5'd7; dstE = 5'd7; wenE = 1; loadE = 1;
    cycle();
    chk("lu_cnt", a_cnt, 4'd1);
    idle(); src_en = 3'b010; src_addr[1] = 5'd7; dstM = 5'd7; wenM = 1;
    cycle();
    chk("lu_m_sel", a_sel[1], 2'd2);

    // x0 never matches; FWD_EN=0 stalls on B-stage match
    idle(); src_en = 3'b001; dstE = 5'd0; wenE = 1; loadE = 1;
    cycle();
    idle(); src_en = 3'b001; src_addr[0] = 5'd3; dstB = 5'd3; wenB = 1;
    cycle();
    idle();
    cycle();

    // MDU op, done on the fourth cycle after start
    clr = 1; cycle(); idle();
    start = 1; cycle(); start = 0;
    repeat (3) cycle();
    done = 1; cycle(); done = 0;
    chk("mdu_cnt", a_cnt, 4'd4);
    cycle();

    // Bus stall masks a taken branch, branch flushes on release
    idle(); bus = 1; branchE = 1;
    cycle();
    bus = 0;
    cycle();
    idle();

    // Counter saturation and clear during stall
    clr = 1; cycle(); clr = 0;
    bus = 1;
    repeat (18) cycle();
    chk("cnt_sat", a_cnt, 4'hF);
    clr = 1; cycle(); clr = 0;
    chk("cnt_clr", a_cnt, 4'h0);
    idle();

    // Reset in the middle of an MDU op
    start = 1; cycle(); start = 0; cycle();
    rst_n = 0; cycle(); rst_n = 1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      src_en  = 3'($urandom);
      for (int k = 0; k < 3; k++) src_addr[k] = 5'($urandom_range(0, 5));
      dstE    = 5'($urandom_range(0, 5));
      dstM    = 5'($urandom_range(0, 5));
      dstB    = 5'($urandom_range(0, 5));
      wenE    = ($urandom_range(0, 3) != 0);
      wenM    = ($urandom_range(0, 3) != 0);
      wenB    = ($urandom_range(0, 3) != 0);
      loadE   = ($urandom_range(0, 2) == 0);
      jalD    = ($urandom_range(0, 5) == 0);
      branchE = ($urandom_range(0, 7) == 0);
      bus     = ($urandom_range(0, 7) == 0);
      start   = ($urandom_range(0, 5) == 0);
      done    = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
